// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Steps the lit position of a 3-to-8 LED decoder through 0..7 at a rate set
//   by a free-running divider. It produces the decoder select code and enable
//   pattern; the decoder keeps ownership of the active-low LED encoding.
//
// Ports
//   clk   : system clock
//   rst   : synchronous active-high reset
//   start : begins a scan when idle (level, sampled each clock)
//   stop  : aborts a scan; wins over start and over a coincident step
//   mode  : 00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single-shot up
//   sel   : decoder select code
//   en    : decoder enable pattern (3'b100 active, 3'b000 all off)
//   busy  : high while scanning
//   done  : one-cycle pulse when a single-shot scan completes
//
// All outputs are registered; en/busy/done are decoded from the next state.
module decoder_scan_ctrl #(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_MAX   = 24'd9_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [2:0] sel,
  output logic [2:0] en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_PING = 2'b10;
  localparam logic [1:0] M_ONE  = 2'b11;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b000;

  state_t               state_q, state_d;
  logic [2:0]           sel_q,   sel_d;
  logic [2:0]           en_q,    en_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;
  logic [DIV_WIDTH-1:0] div_q,   div_d;
  logic [1:0]           mode_q,  mode_d;
  logic                 dir_q,   dir_d;   // 0 = up, 1 = down (ping-pong only)
  logic                 tick;

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    div_d   = div_q;
    mode_d  = mode_q;
    dir_d   = dir_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          mode_d  = mode;
          div_d   = '0;
          sel_d   = (mode == M_DOWN) ? 3'd7 : 3'd0;
          dir_d   = 1'b0;
        end
      end

      RUN: begin
        // stop freezes both the divider and sel, even on a tick cycle
        if (stop) begin
          state_d = IDLE;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) begin
            unique case (mode_q)
              M_UP:   sel_d = sel_q + 3'd1;
              M_DOWN: sel_d = sel_q - 3'd1;
              M_PING: begin
                // turn around at the endpoints so each is shown for one step
                if (!dir_q) begin
                  if (sel_q == 3'd7) begin
                    sel_d = 3'd6;
                    dir_d = 1'b1;
                  end else begin
                    sel_d = sel_q + 3'd1;
                  end
                end else begin
                  if (sel_q == 3'd0) begin
                    sel_d = 3'd1;
                    dir_d = 1'b0;
                  end else begin
                    sel_d = sel_q - 3'd1;
                  end
                end
              end
              M_ONE: begin
                if (sel_q == 3'd7) state_d = DONE;
                else               sel_d   = sel_q + 3'd1;
              end
              default: sel_d = sel_q;
            endcase
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    en_d   = (state_d == IDLE) ? EN_OFF : EN_ON;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      en_q    <= EN_OFF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      mode_q  <= M_UP;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
